bin_to_bcd_converter: RTL and testbench
=======================================

Name: bin_to_bcd_converter

Overview:
- Sequential shift-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the per-digit seven-segment decoders; each 4-bit BCD nibble drives one decoder's digit input.
- Start/ready/done handshake; holds its last result so the displays stay stable between conversions.
- Also produces a leading-zero blank mask that display logic can use to suppress leading zeros.

Parameters:
- BIN_WIDTH, 16, width of the binary input; this is also the number of SHIFT cycles.
- DIGITS, 5, number of BCD output digits; digit 0 is the least significant.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only when ready=1.
- bin_in  in  BIN_WIDTH  unsigned value; captured on the accepted start cycle only.
- ready  out  1  high only in IDLE.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; bcd_out, blank and overflow are valid from this cycle.
- bcd_out  out  4*DIGITS  packed BCD, digit k in bits [4k+3:4k] with MSB at the high index; wire MSB-first to each decoder input.
- blank  out  DIGITS  bit k=1 means digit k is a leading zero; bit 0 is always 0.
- overflow  out  1  input exceeded 10^DIGITS-1; held with the result.

Behaviour:
- Reset (reset_n=0 at a clock edge) from any state, including mid-conversion:
  - state=IDLE, shift register and counter cleared.
  - bcd_out=0, blank={DIGITS-1 ones, 0}, overflow=0, done=0, ready=1, busy=0.
  - Any in-flight conversion is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T: capture bin_in into the binary shift register, clear the BCD scratch register, set counter=0, go to SHIFT.
  - start=0: stay in IDLE; outputs hold.
- SHIFT (one input bit per cycle):
  - First, every scratch nibble >=5 gets +3, all nibbles in parallel.
  - Then shift {scratch, binary} left by 1.
  - Any 1 leaving the top nibble sets a sticky internal overflow flag.
  - counter increments; after the cycle with counter=BIN_WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - Registered outputs are updated at the edge entering DONE, so done=1 and the new results are visible during the DONE cycle.
  - If overflow: bcd_out = all digits 9, overflow=1. Otherwise bcd_out = scratch, overflow=0.
  - blank[k]=1 iff digits DIGITS-1 down to k are all zero, for k>=1.
  - Next state IDLE.
- Latency: start accepted at edge T; SHIFT occupies cycles T+1 .. T+BIN_WIDTH; done=1 in cycle T+BIN_WIDTH+1; ready returns the cycle after that.
- Throughput: one conversion per BIN_WIDTH+2 cycles with start held high.
- start while busy (SHIFT or DONE): ignored, not queued. bin_in changes after capture have no effect.
- Outputs are stable except on the DONE update or reset; no glitching between conversions.
- Widths:
  - Scratch register is 4*DIGITS bits; counter is clog2(BIN_WIDTH)+1 bits.
  - No overflow is possible when DIGITS >= ceil(BIN_WIDTH*log10(2)); the logic still exists.
- bin_in=0 gives all-zero digits and blank = all ones except bit 0.

Decomposition:
- Package bcd_pkg:
  - State enum (IDLE/SHIFT/DONE).
  - Function add3_adjust(nibble): returns the nibble +3 if it is >=5, else unchanged.
  - Constant BCD_NINE=4'd9.
- Sub-module bcd_digit_adjust: one-nibble combinational add-3 cell, instantiated DIGITS times via generate.
- FSM, shift registers and output registers stay in the top module.

Test Plan:
- Default params, bin_in=1234, start pulse → done exactly 17 cycles later; bcd_out=0x01234, blank=5'b10000, overflow=0.
- bin_in=65535 → bcd_out=0x65535, blank=0, overflow=0. bin_in=0 → bcd_out=0x00000, blank=5'b11110.
- DIGITS=4, bin_in=12345 → overflow=1, bcd_out=0x9999. Follow with bin_in=9999 → overflow=0, bcd_out=0x9999.
- Start 1234, then pulse start with bin_in=777 at SHIFT cycle 5 and in the DONE cycle → both ignored; result 0x01234; a single done pulse; ready low throughout.
- Start 4321; assert reset_n=0 at SHIFT cycle 8 → next cycle all outputs at reset values, no done pulse. A fresh start with 42 gives 0x00042 after 17 cycles.
- start held high, bin_in changing every cycle → a conversion is accepted only at each ready cycle, every 18 cycles. Each result matches the bin_in sampled at its acceptance edge, and bcd_out holds between done pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
// Holds FSM encoding, the add-3 adjust function and BCD constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic [3:0] add3_adjust(
    input logic [3:0] nibble
  );
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit add-3 cell applied before each double-dabble shift.
// Purely combinational; one instance per BCD digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = add3_adjust(d);

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to packed BCD converter.
// Results and the leading-zero mask hold until the next conversion.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic [DIGITS-1:0] BLANK_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [SW-1:0]        scr;
  logic [SW-1:0]        adj;
  logic [SW-1:0]        nxt_scr;
  logic [SW-1:0]        nines;
  logic [SW-1:0]        res;
  logic [DIGITS-1:0]    blk;
  logic [CW-1:0]        cnt;
  logic                 ovf_s;
  logic                 nxt_ovf;
  logic                 last;
  logic                 z;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (scr[4*k +: 4]),
      .q (adj[4*k +: 4])
    );
    assign nines[4*k +: 4] = BCD_NINE;
  end

  // A 1 leaving the top nibble means the value no longer fits.
  assign nxt_scr = {adj[SW-2:0], bin_sr[BIN_WIDTH-1]};
  assign nxt_ovf = ovf_s | adj[SW-1];
  assign res     = nxt_ovf ? nines : nxt_scr;
  assign last    = (cnt == CW'(BIN_WIDTH - 1));

  always_comb begin
    blk = '0;
    z   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z      = z & (res[4*k +: 4] == 4'd0);
      blk[k] = z;
    end
  end

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_SHIFT) || (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bin_sr   <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_s    <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            scr    <= '0;
            cnt    <= '0;
            ovf_s  <= 1'b0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
          scr    <= nxt_scr;
          ovf_s  <= nxt_ovf;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            bcd_out  <= res;
            blank    <= blk;
            overflow <= nxt_ovf;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter.
// Runs a 5-digit and a 4-digit instance from shared stimulus.
module tb_bin_to_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;

  logic        ready5, busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;
  logic        ready4, busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .ready(ready5), .busy(busy5), .done(done5),
    .bcd_out(bcd5), .blank(blank5), .overflow(ovf5)
  );

  bin_to_bcd_converter #(.BIN_WIDTH(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .ready(ready4), .busy(busy4), .done(done4),
    .bcd_out(bcd4), .blank(blank4), .overflow(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic run(input logic [15:0] v, input string tag);
    int lat;
    start  = 1'b1;
    bin_in = v;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done5 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 17);
  endtask

  initial begin
    int lat_ok;
    int nready;
    int ndone;
    int last_acc;
    int hold_bad;
    int acc_bad;
    int cyc;
    logic [19:0] last_bcd;
    logic [15:0] q[$];

    // reset state
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_ready", ready5, 1);
    chk("rst_busy", busy5, 0);
    chk("rst_done", done5, 0);
    chk("rst_bcd", bcd5, 20'h00000);
    chk("rst_blank", blank5, 5'b11110);
    chk("rst_ovf", ovf5, 0);
    chk("rst_blank4", blank4, 4'b1110);

    // 1234
    run(16'd1234, "c1234");
    chk("c1234_bcd", bcd5, 20'h01234);
    chk("c1234_blank", blank5, 5'b10000);
    chk("c1234_ovf", ovf5, 0);
    chk("c1234_busy", busy5, 1);
    chk("c1234_bcd4", bcd4, 16'h1234);
    chk("c1234_ovf4", ovf4, 0);
    tick();
    chk("c1234_ready_after", ready5, 1);
    chk("c1234_done_after", done5, 0);
    chk("c1234_hold", bcd5, 20'h01234);

    // 65535
    run(16'd65535, "cmax");
    chk("cmax_bcd", bcd5, 20'h65535);
    chk("cmax_blank", blank5, 5'b00000);
    chk("cmax_ovf", ovf5, 0);
    chk("cmax_ovf4", ovf4, 1);
    chk("cmax_bcd4", bcd4, 16'h9999);
    tick();

    // 0
    run(16'd0, "czero");
    chk("czero_bcd", bcd5, 20'h00000);
    chk("czero_blank", blank5, 5'b11110);
    chk("czero_ovf", ovf5, 0);
    tick();

    // 4-digit overflow boundary
    run(16'd12345, "c12345");
    chk("c12345_bcd", bcd5, 20'h12345);
    chk("c12345_ovf4", ovf4, 1);
    chk("c12345_bcd4", bcd4, 16'h9999);
    chk("c12345_blank4", blank4, 4'b0000);
    tick();
    run(16'd9999, "c9999");
    chk("c9999_ovf4", ovf4, 0);
    chk("c9999_bcd4", bcd4, 16'h9999);
    chk("c9999_bcd", bcd5, 20'h09999);
    chk("c9999_blank", blank5, 5'b10000);
    tick();

    // start while busy is ignored
    start  = 1'b1;
    bin_in = 16'd1234;
    tick();
    nready = 0;
    ndone  = 0;
    for (int i = 1; i <= 16; i++) begin
      start  = (i == 5);
      bin_in = (i == 5) ? 16'd777 : 16'd1234;
      if (ready5) nready++;
      if (done5) ndone++;
      tick();
    end
    start  = 1'b1;
    bin_in = 16'd777;
    if (ready5) nready++;
    if (done5) ndone++;
    chk("busy_done_cycle", done5, 1);
    chk("busy_bcd", bcd5, 20'h01234);
    tick();
    start = 1'b0;
    if (done5) ndone++;
    chk("busy_ready_low", nready, 0);
    chk("busy_ndone", ndone, 1);
    chk("busy_back_ready", ready5, 1);
    tick();
    chk("busy_not_queued", ready5, 1);

    // reset mid-conversion
    start  = 1'b1;
    bin_in = 16'd4321;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_ready", ready5, 1);
    chk("mrst_busy", busy5, 0);
    chk("mrst_bcd", bcd5, 20'h00000);
    chk("mrst_blank", blank5, 5'b11110);
    chk("mrst_ovf", ovf5, 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done5) ndone++;
      tick();
    end
    chk("mrst_no_done", ndone, 0);
    run(16'd42, "c42");
    chk("c42_bcd", bcd5, 20'h00042);
    chk("c42_blank", blank5, 5'b11100);
    tick();

    // start held high with changing input
    start    = 1'b1;
    last_acc = -1;
    acc_bad  = 0;
    hold_bad = 0;
    ndone    = 0;
    last_bcd = bcd5;
    cyc = 0;
    while (cyc < 60 || (q.size() != 0 && cyc < 100)) begin
      if (cyc >= 60) start = 1'b0;
      bin_in = 16'(cyc * 4099 + 17);
      if (ready5 && start) begin
        if (last_acc >= 0 && cyc - last_acc != 18) acc_bad++;
        last_acc = cyc;
        q.push_back(bin_in);
      end
      if (done5) begin
        ndone++;
        if (q.size() == 0) begin
          chk("held_spurious_done", 1, 0);
        end else begin
          chk("held_result", bcd5, to_bcd(int'(q.pop_front())));
        end
        last_bcd = bcd5;
      end else if (bcd5 !== last_bcd) begin
        hold_bad++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("held_spacing", acc_bad, 0);
    chk("held_hold", hold_bad, 0);
    chk("held_ndone", ndone, 4);
    chk("held_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
